// File: rtl/riscv_pkg.sv
// Shared load/store types, exception cause codes and the LSU state encoding.
package riscv_pkg;

  typedef enum logic {
    LSU_OP_LD = 1'b0,
    LSU_OP_ST = 1'b1
  } lsu_op_e;

  typedef enum logic [2:0] {
    LSU_BYTE   = 3'd0,
    LSU_HALF   = 3'd1,
    LSU_WORD   = 3'd2,
    LSU_U_BYTE = 3'd3,
    LSU_U_HALF = 3'd4
  } lsu_dtype_e;

  localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
  localparam logic [5:0] EXC_LD_FAULT    = 6'd5;
  localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;
  localparam logic [5:0] EXC_ST_FAULT    = 6'd7;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_HOLD = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication,
// load extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  lsu_dtype_e        i_dtype,
  input  logic [1:0]        i_off,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [3:0]        o_be,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_rdata_ext,
  output logic              o_misalign
);

  logic [XLEN-1:0] w_shift;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0] s;
    s = b;
    return sgn ? {{24{s[7]}}, b} : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] s;
    s = h;
    return sgn ? {{16{s[15]}}, h} : {16'd0, h};
  endfunction

  // Lane selection per access size; the addressed byte/half is moved to bit 0 for loads.
  always_comb begin
    w_shift     = i_rdata >> {i_off, 3'b000};
    o_be        = 4'b0000;
    o_wdata     = i_wdata;
    o_rdata_ext = i_rdata;
    o_misalign  = 1'b0;
    case (i_dtype)
      LSU_BYTE, LSU_U_BYTE: begin
        o_be        = 4'b0001 << i_off;
        o_wdata     = {4{i_wdata[7:0]}};
        o_rdata_ext = ext8(w_shift[7:0], i_dtype == LSU_BYTE);
      end
      LSU_HALF, LSU_U_HALF: begin
        o_be        = 4'b0011 << {i_off[1], 1'b0};
        o_wdata     = {2{i_wdata[15:0]}};
        o_rdata_ext = ext16(w_shift[15:0], i_dtype == LSU_HALF);
        o_misalign  = i_off[0];
      end
      LSU_WORD: begin
        o_be        = 4'b1111;
        o_wdata     = i_wdata;
        o_rdata_ext = i_rdata;
        o_misalign  = (i_off != 2'b00);
      end
      default: begin
        o_be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM pipeline stage: issues one req/gnt + rvalid bus transaction per
// load/store, aligns load data and updates the WB registers.
module lsu_mem_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_M,
  output logic              ready_mem,
  input  logic              lsu_en_mem,
  input  lsu_op_e           lsu_op_mem,
  input  lsu_dtype_e        lsu_dtype_mem,
  input  logic [ADDR_W-1:0] lsu_addr_mem,
  input  logic [XLEN-1:0]   lsu_wdata_mem,
  input  logic              rd_wr_en_mem,
  input  logic [4:0]        rd_wr_addr_mem,
  input  logic [XLEN-1:0]   rd_wr_data_mem,
  input  logic              exc_taken_mem,
  input  logic [5:0]        exc_cause_mem,
  input  logic [XLEN-1:0]   exc_tval_mem,
  output logic              data_req,
  output logic [ADDR_W-1:0] data_addr,
  output logic              data_we,
  output logic [3:0]        data_be,
  output logic [XLEN-1:0]   data_wdata,
  input  logic              data_gnt,
  input  logic              data_rvalid,
  input  logic [XLEN-1:0]   data_rdata,
  input  logic              data_err,
  output logic              rd_wr_en_wb,
  output logic [4:0]        rd_wr_addr_wb,
  output logic [XLEN-1:0]   rd_wr_data_wb,
  output logic              exc_taken_wb,
  output logic [5:0]        exc_cause_wb,
  output logic [XLEN-1:0]   exc_tval_wb,
  output logic              forward_mem_en,
  output logic [4:0]        forward_mem_addr,
  output logic [XLEN-1:0]   forward_mem_wdata
);

  lsu_state_e      r_state;
  logic [XLEN-1:0] r_hold_data_p1;
  logic            r_hold_err_p1;

  logic            w_misalign;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_rdata_ext;
  logic            w_is_store;
  logic            w_is_load;
  logic            w_need_acc;
  logic            w_wait_rv;
  logic            w_in_hold;
  logic            w_bus_err;
  logic [XLEN-1:0] w_load_res;
  logic            w_exc;
  logic [5:0]      w_cause;
  logic [XLEN-1:0] w_tval;
  logic            w_ready;

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_dtype     (lsu_dtype_mem),
    .i_off       (lsu_addr_mem[1:0]),
    .i_wdata     (lsu_wdata_mem),
    .i_rdata     (data_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rdata_ext (w_rdata_ext),
    .o_misalign  (w_misalign)
  );

  // Access decision, completion detection and exception selection for the current MEM instruction.
  always_comb begin
    w_is_store = (lsu_op_mem == LSU_OP_ST);
    w_is_load  = lsu_en_mem & ~w_is_store;
    w_need_acc = lsu_en_mem & ~exc_taken_mem & ~w_misalign;
    w_wait_rv  = (r_state == LSU_WAIT) & data_rvalid;
    w_in_hold  = (r_state == LSU_HOLD);
    // A response parked in HOLD takes precedence over whatever sits on the bus now.
    w_load_res = w_in_hold ? r_hold_data_p1 : w_rdata_ext;
    w_bus_err  = (w_wait_rv & data_err) | (w_in_hold & r_hold_err_p1);
    w_exc      = 1'b0;
    w_cause    = 6'd0;
    w_tval     = '0;
    if (exc_taken_mem) begin
      w_exc   = 1'b1;
      w_cause = exc_cause_mem;
      w_tval  = exc_tval_mem;
    end else if (lsu_en_mem & w_misalign) begin
      w_exc   = 1'b1;
      w_cause = w_is_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
      w_tval  = lsu_addr_mem;
    end else if (w_bus_err) begin
      w_exc   = 1'b1;
      w_cause = w_is_store ? EXC_ST_FAULT : EXC_LD_FAULT;
      w_tval  = lsu_addr_mem;
    end
    w_ready = ~stall_M & (((r_state == LSU_IDLE) & ~w_need_acc) | w_wait_rv | w_in_hold);
  end

  // Bus request side and back-pressure/bypass outputs; EX holds the address and data stable while not ready.
  always_comb begin
    data_req          = ~reset & (((r_state == LSU_IDLE) & w_need_acc) | (r_state == LSU_REQ));
    data_addr         = {lsu_addr_mem[ADDR_W-1:2], 2'b00};
    data_we           = w_is_store;
    data_be           = w_be;
    data_wdata        = w_wdata;
    ready_mem         = w_ready;
    forward_mem_en    = rd_wr_en_mem & w_ready & ~w_exc;
    forward_mem_addr  = rd_wr_addr_mem;
    forward_mem_wdata = w_is_load ? w_load_res : rd_wr_data_mem;
  end

  // Transaction FSM: at most one outstanding access, reset drops any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LSU_IDLE;
    end else begin
      case (r_state)
        LSU_IDLE: if (w_need_acc) r_state <= data_gnt ? LSU_WAIT : LSU_REQ;
        LSU_REQ:  if (data_gnt) r_state <= LSU_WAIT;
        LSU_WAIT: if (data_rvalid) r_state <= stall_M ? LSU_HOLD : LSU_IDLE;
        LSU_HOLD: if (!stall_M) r_state <= LSU_IDLE;
        default:  r_state <= LSU_IDLE;
      endcase
    end
  end

  // --- response buffer (p1): keeps a response that arrived under stall ---
  always_ff @(posedge clk) begin
    if (w_wait_rv) begin
      r_hold_data_p1 <= w_rdata_ext;
      r_hold_err_p1  <= data_err;
    end
  end

  // --- MEM -> WB boundary: hold on stall, capture when ready, otherwise insert a bubble ---
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_wr_en_wb   <= 1'b0;
      rd_wr_addr_wb <= 5'd0;
      rd_wr_data_wb <= '0;
      exc_taken_wb  <= 1'b0;
      exc_cause_wb  <= 6'd0;
      exc_tval_wb   <= '0;
    end else if (stall_M) begin
      rd_wr_en_wb   <= rd_wr_en_wb;
    end else if (w_ready) begin
      rd_wr_en_wb   <= rd_wr_en_mem & ~w_exc;
      rd_wr_addr_wb <= rd_wr_addr_mem;
      rd_wr_data_wb <= w_is_load ? w_load_res : rd_wr_data_mem;
      exc_taken_wb  <= w_exc;
      exc_cause_wb  <= w_cause;
      exc_tval_wb   <= w_tval;
    end else begin
      rd_wr_en_wb   <= 1'b0;
      exc_taken_wb  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed and randomized bench for lsu_mem_stage with a byte-level reference model.
module tb_lsu_mem_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall_M;
  logic        ready_mem;
  logic        lsu_en_mem;
  lsu_op_e     lsu_op_mem;
  lsu_dtype_e  lsu_dtype_mem;
  logic [31:0] lsu_addr_mem;
  logic [31:0] lsu_wdata_mem;
  logic        rd_wr_en_mem;
  logic [4:0]  rd_wr_addr_mem;
  logic [31:0] rd_wr_data_mem;
  logic        exc_taken_mem;
  logic [5:0]  exc_cause_mem;
  logic [31:0] exc_tval_mem;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        rd_wr_en_wb;
  logic [4:0]  rd_wr_addr_wb;
  logic [31:0] rd_wr_data_wb;
  logic        exc_taken_wb;
  logic [5:0]  exc_cause_wb;
  logic [31:0] exc_tval_wb;
  logic        forward_mem_en;
  logic [4:0]  forward_mem_addr;
  logic [31:0] forward_mem_wdata;

  int n_chk = 0;
  int n_err = 0;
  int n_hs  = 0;

  lsu_mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .stall_M(stall_M), .ready_mem(ready_mem),
    .lsu_en_mem(lsu_en_mem), .lsu_op_mem(lsu_op_mem), .lsu_dtype_mem(lsu_dtype_mem),
    .lsu_addr_mem(lsu_addr_mem), .lsu_wdata_mem(lsu_wdata_mem),
    .rd_wr_en_mem(rd_wr_en_mem), .rd_wr_addr_mem(rd_wr_addr_mem), .rd_wr_data_mem(rd_wr_data_mem),
    .exc_taken_mem(exc_taken_mem), .exc_cause_mem(exc_cause_mem), .exc_tval_mem(exc_tval_mem),
    .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_be(data_be),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_err(data_err),
    .rd_wr_en_wb(rd_wr_en_wb), .rd_wr_addr_wb(rd_wr_addr_wb), .rd_wr_data_wb(rd_wr_data_wb),
    .exc_taken_wb(exc_taken_wb), .exc_cause_wb(exc_cause_wb), .exc_tval_wb(exc_tval_wb),
    .forward_mem_en(forward_mem_en), .forward_mem_addr(forward_mem_addr),
    .forward_mem_wdata(forward_mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted bus requests (handshakes).
  always @(posedge clk) if (data_req && data_gnt) n_hs <= n_hs + 1;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lsu_en_mem = 1'b0; rd_wr_en_mem = 1'b0; exc_taken_mem = 1'b0; stall_M = 1'b0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0;
  endtask

  // Reference model: access size in bytes.
  function automatic int dsize(input lsu_dtype_e dt);
    if (dt == LSU_BYTE || dt == LSU_U_BYTE) return 1;
    if (dt == LSU_HALF || dt == LSU_U_HALF) return 2;
    return 4;
  endfunction

  // Reference model: value the load writes back, from plain arithmetic.
  function automatic logic [31:0] model_load(input lsu_dtype_e dt, input int off, input logic [31:0] rd);
    logic [31:0] v;
    int n;
    n = dsize(dt);
    v = rd >> (8 * off);
    if (n == 1) begin
      v = v % 256;
      if (dt == LSU_BYTE && v >= 128) v = v - 256;
    end else if (n == 2) begin
      v = v % 65536;
      if (dt == LSU_HALF && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  // Reference model: lane i carries store byte (i mod size).
  function automatic logic [31:0] model_wdata(input lsu_dtype_e dt, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = dsize(dt);
    r = 0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_be(input lsu_dtype_e dt, input int off);
    int n;
    n = dsize(dt);
    return (((32'd1 << n) - 1) << off) & 32'hF;
  endfunction

  // One load/store from entry into MEM until it reaches WB.
  task automatic run_lsu(input logic st, input lsu_dtype_e dt, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         input int gdly, input int sdly, input logic err);
    int          n, off, hs0;
    logic        mis;
    logic [31:0] exp_ld, exp_wd, exp_be, exp_addr, alu;
    logic [4:0]  rd;
    n        = dsize(dt);
    off      = int'(addr % 4);
    mis      = (addr % n) != 0;
    exp_ld   = model_load(dt, off, rdat);
    exp_wd   = model_wdata(dt, wd);
    exp_be   = model_be(dt, off);
    exp_addr = addr - (addr % 4);
    rd       = 5'($urandom_range(1, 31));
    alu      = $urandom;
    hs0      = n_hs;
    lsu_en_mem = 1'b1; lsu_op_mem = st ? LSU_OP_ST : LSU_OP_LD; lsu_dtype_mem = dt;
    lsu_addr_mem = addr; lsu_wdata_mem = wd;
    rd_wr_en_mem = !st; rd_wr_addr_mem = rd; rd_wr_data_mem = alu;
    exc_taken_mem = 1'b0; stall_M = 1'b0;
    data_gnt = (gdly == 0); data_rvalid = 1'b0; data_err = 1'b0;
    #1;
    if (mis) begin
      chk("mis_req", 32'(data_req), 32'd0);
      chk("mis_ready", 32'(ready_mem), 32'd1);
      chk("mis_fwd_en", 32'(forward_mem_en), 32'd0);
      step(); idle_inputs(); #1;
      chk("mis_exc", 32'(exc_taken_wb), 32'd1);
      chk("mis_cause", 32'(exc_cause_wb), st ? 32'd6 : 32'd4);
      chk("mis_tval", exc_tval_wb, addr);
      chk("mis_wb_en", 32'(rd_wr_en_wb), 32'd0);
      chk("mis_no_bus", 32'(n_hs - hs0), 32'd0);
      return;
    end
    chk("req", 32'(data_req), 32'd1);
    chk("addr", data_addr, exp_addr);
    chk("we", 32'(data_we), 32'(st));
    chk("be", 32'(data_be), exp_be);
    chk("wdata", data_wdata, exp_wd);
    chk("ready_issue", 32'(ready_mem), 32'd0);
    for (int k = 1; k <= gdly; k++) begin
      step();
      data_gnt = (k == gdly);
      #1;
      chk("req_held", 32'(data_req), 32'd1);
      chk("addr_held", data_addr, exp_addr);
      chk("be_held", 32'(data_be), exp_be);
      chk("wdata_held", data_wdata, exp_wd);
      chk("ready_req", 32'(ready_mem), 32'd0);
      chk("bubble_req", 32'(rd_wr_en_wb), 32'd0);
    end
    step();
    data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = rdat; data_err = err; stall_M = (sdly > 0);
    #1;
    chk("req_wait", 32'(data_req), 32'd0);
    chk("ready_rv", 32'(ready_mem), 32'(sdly == 0));
    chk("bubble_wait", 32'({rd_wr_en_wb, exc_taken_wb}), 32'd0);
    for (int k = 1; k <= sdly; k++) begin
      step();
      data_rvalid = 1'b0; data_rdata = $urandom; data_err = 1'b0; stall_M = (k < sdly);
      #1;
      chk("ready_hold", 32'(ready_mem), 32'(k == sdly));
      chk("req_hold", 32'(data_req), 32'd0);
    end
    chk("fwd_en", 32'(forward_mem_en), 32'(!st && !err));
    if (!st && !err) begin
      chk("fwd_data", forward_mem_wdata, exp_ld);
      chk("fwd_addr", 32'(forward_mem_addr), 32'(rd));
    end
    step(); idle_inputs(); #1;
    chk("wb_en", 32'(rd_wr_en_wb), 32'(!st && !err));
    chk("wb_exc", 32'(exc_taken_wb), 32'(err));
    if (err) begin
      chk("wb_cause", 32'(exc_cause_wb), st ? 32'd7 : 32'd5);
      chk("wb_tval", exc_tval_wb, addr);
    end
    if (!st && !err) begin
      chk("wb_data", rd_wr_data_wb, exp_ld);
      chk("wb_addr", 32'(rd_wr_addr_wb), 32'(rd));
    end
    chk("one_txn", 32'(n_hs - hs0), 32'd1);
  endtask

  initial begin
    logic       st;
    lsu_dtype_e dt;
    logic [31:0] a;
    reset = 1'b1; idle_inputs();
    lsu_op_mem = LSU_OP_LD; lsu_dtype_mem = LSU_WORD; lsu_addr_mem = 0; lsu_wdata_mem = 0;
    rd_wr_addr_mem = 0; rd_wr_data_mem = 0; exc_cause_mem = 0; exc_tval_mem = 0; data_rdata = 0;
    step(); step();
    chk("rst_wb_en", 32'(rd_wr_en_wb), 32'd0);
    chk("rst_exc", 32'(exc_taken_wb), 32'd0);
    chk("rst_data", rd_wr_data_wb, 32'd0);
    chk("rst_cause", 32'(exc_cause_wb), 32'd0);
    chk("rst_tval", exc_tval_wb, 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    reset = 1'b0;
    step();

    // Non-LSU instruction, then a downstream stall holding WB.
    rd_wr_en_mem = 1'b1; rd_wr_addr_mem = 5'd7; rd_wr_data_mem = 32'h1111_2222;
    #1;
    chk("alu_ready", 32'(ready_mem), 32'd1);
    chk("alu_fwd_en", 32'(forward_mem_en), 32'd1);
    chk("alu_fwd_data", forward_mem_wdata, 32'h1111_2222);
    step();
    chk("alu_wb_data", rd_wr_data_wb, 32'h1111_2222);
    chk("alu_wb_en", 32'(rd_wr_en_wb), 32'd1);
    rd_wr_data_mem = 32'h3333_4444; stall_M = 1'b1;
    #1;
    chk("stall_ready", 32'(ready_mem), 32'd0);
    step();
    chk("stall_hold", rd_wr_data_wb, 32'h1111_2222);
    stall_M = 1'b0;
    step();
    chk("after_stall", rd_wr_data_wb, 32'h3333_4444);

    // Directed loads/stores.
    idle_inputs();
    run_lsu(1'b0, LSU_BYTE, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
    chk("lb_value", rd_wr_data_wb, 32'hFFFF_FF80);
    run_lsu(1'b0, LSU_U_BYTE, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 1'b0);
    chk("lbu_value", rd_wr_data_wb, 32'h0000_0080);
    run_lsu(1'b1, LSU_HALF, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0, 1'b0);
    run_lsu(1'b0, LSU_WORD, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
    run_lsu(1'b0, LSU_WORD, 32'h400, 32'h0, 32'hCAFE_F00D, 3, 0, 1'b0);
    chk("lw_delay", rd_wr_data_wb, 32'hCAFE_F00D);
    run_lsu(1'b0, LSU_HALF, 32'h402, 32'h0, 32'h8001_7FFF, 0, 2, 1'b0);
    chk("lh_hold", rd_wr_data_wb, 32'hFFFF_8001);
    run_lsu(1'b1, LSU_WORD, 32'h3C, 32'h5555_AAAA, 32'h0, 1, 0, 1'b1);
    chk("sw_err_cause", 32'(exc_cause_wb), 32'd7);
    run_lsu(1'b1, LSU_HALF, 32'h33, 32'h0, 32'h0, 0, 0, 1'b0);

    // Upstream exception passes straight through.
    lsu_en_mem = 1'b1; lsu_op_mem = LSU_OP_LD; lsu_dtype_mem = LSU_WORD; lsu_addr_mem = 32'h40;
    rd_wr_en_mem = 1'b1; exc_taken_mem = 1'b1; exc_cause_mem = 6'd2; exc_tval_mem = 32'hDEAD;
    #1;
    chk("upx_req", 32'(data_req), 32'd0);
    chk("upx_ready", 32'(ready_mem), 32'd1);
    chk("upx_fwd", 32'(forward_mem_en), 32'd0);
    step(); idle_inputs(); #1;
    chk("upx_exc", 32'(exc_taken_wb), 32'd1);
    chk("upx_cause", 32'(exc_cause_wb), 32'd2);
    chk("upx_tval", exc_tval_wb, 32'hDEAD);
    chk("upx_wb_en", 32'(rd_wr_en_wb), 32'd0);

    // Stray rvalid in IDLE is ignored.
    rd_wr_en_mem = 1'b1; rd_wr_addr_mem = 5'd9; rd_wr_data_mem = 32'h0BAD_CAFE;
    data_rvalid = 1'b1; data_rdata = 32'hFFFF_FFFF; data_err = 1'b1;
    #1;
    chk("stray_ready", 32'(ready_mem), 32'd1);
    chk("stray_fwd", forward_mem_wdata, 32'h0BAD_CAFE);
    step(); idle_inputs(); #1;
    chk("stray_wb", rd_wr_data_wb, 32'h0BAD_CAFE);
    chk("stray_exc", 32'(exc_taken_wb), 32'd0);

    // Reset while in REQ drops the request.
    lsu_en_mem = 1'b1; lsu_op_mem = LSU_OP_LD; lsu_dtype_mem = LSU_WORD; lsu_addr_mem = 32'h80;
    rd_wr_en_mem = 1'b1; data_gnt = 1'b0;
    step();
    chk("rq_req", 32'(data_req), 32'd1);
    reset = 1'b1;
    step();
    chk("rq_rst_req", 32'(data_req), 32'd0);
    idle_inputs(); reset = 1'b0;
    #1;
    chk("rq_idle_req", 32'(data_req), 32'd0);
    chk("rq_idle_ready", 32'(ready_mem), 32'd1);
    step();
    run_lsu(1'b0, LSU_HALF, 32'h86, 32'h0, 32'h7F00_1234, 0, 0, 1'b0);

    // Randomized loads and stores.
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      dt = st ? lsu_dtype_e'(3'($urandom_range(0, 2))) : lsu_dtype_e'(3'($urandom_range(0, 4)));
      a  = $urandom;
      run_lsu(st, dt, a, $urandom, $urandom, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
